// File: rtl/saci_pkg.sv
// saci_pkg: shared definitions for the SACI master.
// Holds FSM state codes, the response status enum and frame-length helpers.
package saci_pkg;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_SEND    = 3'd1;
    localparam logic [2:0] S_WAIT    = 3'd2;
    localparam logic [2:0] S_RECOVER = 3'd3;
    localparam logic [2:0] S_RECV    = 3'd4;
    localparam logic [2:0] S_DONE    = 3'd5;

    typedef enum logic [1:0] {
        ST_OK        = 2'd0,
        ST_TIMEOUT   = 2'd1,
        ST_ECHO_ERR  = 2'd2,
        ST_BAD_SLAVE = 2'd3
    } saci_status_e;

    // Index width that stays at least one bit for degenerate sizes.
    function automatic int f_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Header: start bit, rw bit, command, address.
    function automatic int f_hdr_len(input int cmd_w, input int addr_w);
        return 2 + cmd_w + addr_w;
    endfunction

    function automatic int f_req_len(input logic wr, input int cmd_w,
                                     input int addr_w, input int data_w);
        return wr ? f_hdr_len(cmd_w, addr_w) + data_w
                  : f_hdr_len(cmd_w, addr_w);
    endfunction

    // Response length counts the slave's start bit.
    function automatic int f_rsp_len(input logic wr, input int cmd_w,
                                     input int addr_w, input int data_w);
        return wr ? f_hdr_len(cmd_w, addr_w)
                  : f_hdr_len(cmd_w, addr_w) + data_w;
    endfunction

endpackage

// File: rtl/saci_clk_gen.sv
// saci_clk_gen: free-running SACI clock divider (low then high, g_clk_half each).
// Ports: clk_i/reset_i in; saci_clk_o, fall_tick_o, rise_tick_o out.
module saci_clk_gen
    import saci_pkg::*;
#(
    parameter int g_clk_half = 2
) (
    input  logic clk_i,
    input  logic reset_i,
    output logic saci_clk_o,
    output logic fall_tick_o,
    output logic rise_tick_o
);

    localparam int CW = f_w(g_clk_half);
    localparam logic [CW-1:0] LAST = CW'(g_clk_half - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          clk_q, clk_d;
    logic          wrap;

    always_comb begin
        wrap  = (cnt_q == LAST);
        cnt_d = wrap ? '0 : cnt_q + 1'b1;
        clk_d = wrap ? ~clk_q : clk_q;
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            cnt_q <= '0;
            clk_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            clk_q <= clk_d;
        end
    end

    // Ticks flag the cycle whose closing edge toggles saci_clk_o, so logic
    // acting on a tick updates on the same edge as the SACI clock.
    assign saci_clk_o  = clk_q;
    assign fall_tick_o = wrap & clk_q;
    assign rise_tick_o = wrap & ~clk_q;

endmodule

// File: rtl/saci_master_ctrl.sv
// saci_master_ctrl: SACI master; serialises frames, checks the echoed header,
// retries a stuck slave. Ports: req_* handshake in, rsp_* status out, saci_* pins.
module saci_master_ctrl
    import saci_pkg::*;
#(
    parameter int g_cmd_w      = 7,
    parameter int g_addr_w     = 12,
    parameter int g_data_w     = 32,
    parameter int g_num_slaves = 3,
    parameter int g_clk_half   = 2,
    parameter int g_timeout    = 100,
    parameter int g_retries    = 3,
    parameter int g_recover    = 4
) (
    input  logic                             clk_i,
    input  logic                             reset_i,
    input  logic                             req_valid_i,
    output logic                             req_ready_o,
    input  logic                             req_write_i,
    input  logic [f_w(g_num_slaves)-1:0]     req_slave_i,
    input  logic [g_cmd_w-1:0]               req_cmd_i,
    input  logic [g_addr_w-1:0]              req_addr_i,
    input  logic [g_data_w-1:0]              req_wdata_i,
    output logic                             rsp_valid_o,
    output logic [g_data_w-1:0]              rsp_rdata_o,
    output logic [1:0]                       rsp_status_o,
    output logic [f_w(g_retries+1)-1:0]      rsp_retries_o,
    output logic                             busy_o,
    output logic                             saci_clk_o,
    output logic                             saci_cmd_o,
    output logic [g_num_slaves-1:0]          saci_sel_n_o,
    input  logic                             saci_rsp_i
);

    localparam int HL  = f_hdr_len(g_cmd_w, g_addr_w);
    localparam int EW  = HL - 1;
    localparam int TXW = HL + g_data_w;
    localparam int RXW = EW + g_data_w;
    localparam int SW  = f_w(g_num_slaves);
    localparam int RW  = f_w(g_retries + 1);
    localparam int BW  = f_w(TXW + 1);
    localparam int REC = g_recover * 2 * g_clk_half;
    localparam int TW  = f_w(((g_timeout > REC) ? g_timeout : REC) + 1);

    localparam logic [BW-1:0] REQ_WR =
        BW'(f_req_len(1'b1, g_cmd_w, g_addr_w, g_data_w));
    localparam logic [BW-1:0] REQ_RD =
        BW'(f_req_len(1'b0, g_cmd_w, g_addr_w, g_data_w));
    localparam logic [BW-1:0] RSP_WR =
        BW'(f_rsp_len(1'b1, g_cmd_w, g_addr_w, g_data_w));
    localparam logic [BW-1:0] RSP_RD =
        BW'(f_rsp_len(1'b0, g_cmd_w, g_addr_w, g_data_w));
    localparam logic [TW-1:0] TO_LAST  = TW'(g_timeout - 1);
    localparam logic [TW-1:0] REC_LAST = TW'(REC - 1);

    logic [2:0]              state_q, state_d;
    logic                    write_q, write_d;
    logic [SW-1:0]           slave_q, slave_d;
    logic [g_cmd_w-1:0]      cmd_q, cmd_d;
    logic [g_addr_w-1:0]     addr_q, addr_d;
    logic [g_data_w-1:0]     wdata_q, wdata_d;
    logic [TXW-1:0]          tx_q, tx_d;
    logic [RXW-2:0]          rx_q, rx_d;
    logic [BW-1:0]           cnt_q, cnt_d;
    logic [TW-1:0]           tmr_q, tmr_d;
    logic [RW-1:0]           retry_q, retry_d;
    logic [g_num_slaves-1:0] sel_n_q, sel_n_d;
    logic                    mosi_q, mosi_d;
    logic                    rsp_valid_q, rsp_valid_d;
    logic [g_data_w-1:0]     rsp_rdata_q, rsp_rdata_d;
    saci_status_e            rsp_status_q, rsp_status_d;
    logic [RW-1:0]           rsp_retries_q, rsp_retries_d;

    logic                    fall_tick, rise_tick;
    logic                    good_slave;
    logic [g_data_w-1:0]     in_wdata;
    logic [TXW-1:0]          in_frame, q_frame;
    logic [BW-1:0]           req_len, rsp_len;
    logic [RXW-1:0]          rx_nxt;
    logic [EW-1:0]           exp_hdr, got_hdr;

    saci_clk_gen #(
        .g_clk_half  (g_clk_half)
    ) u_clk_gen (
        .clk_i       (clk_i),
        .reset_i     (reset_i),
        .saci_clk_o  (saci_clk_o),
        .fall_tick_o (fall_tick),
        .rise_tick_o (rise_tick)
    );

    always_comb begin
        good_slave = (int'(req_slave_i) < g_num_slaves);
        in_wdata   = req_write_i ? req_wdata_i : '0;
        in_frame   = {1'b1, req_write_i, req_cmd_i, req_addr_i, in_wdata};
        q_frame    = {1'b1, write_q, cmd_q, addr_q, wdata_q};
        req_len    = write_q ? REQ_WR : REQ_RD;
        rsp_len    = write_q ? RSP_WR : RSP_RD;
        rx_nxt     = {rx_q, saci_rsp_i};
        exp_hdr    = {write_q, cmd_q, addr_q};
        // Write echoes end in the header; read echoes lead with it.
        got_hdr    = write_q ? rx_nxt[EW-1:0] : rx_nxt[RXW-1 -: EW];

        state_d       = state_q;
        write_d       = write_q;
        slave_d       = slave_q;
        cmd_d         = cmd_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        tx_d          = tx_q;
        rx_d          = rx_q;
        cnt_d         = cnt_q;
        tmr_d         = tmr_q;
        retry_d       = retry_q;
        sel_n_d       = sel_n_q;
        mosi_d        = mosi_q;
        rsp_valid_d   = 1'b0;
        rsp_rdata_d   = rsp_rdata_q;
        rsp_status_d  = rsp_status_q;
        rsp_retries_d = rsp_retries_q;

        case (state_q)
            S_IDLE: begin
                if (req_valid_i) begin
                    write_d = req_write_i;
                    slave_d = req_slave_i;
                    cmd_d   = req_cmd_i;
                    addr_d  = req_addr_i;
                    wdata_d = in_wdata;
                    tx_d    = in_frame;
                    cnt_d   = '0;
                    tmr_d   = '0;
                    retry_d = '0;
                    if (good_slave) begin
                        state_d = S_SEND;
                        for (int i = 0; i < g_num_slaves; i++) begin
                            sel_n_d[i] = (int'(req_slave_i) != i);
                        end
                    end else begin
                        // Pulse comes from DONE one cycle later.
                        state_d       = S_DONE;
                        rsp_status_d  = ST_BAD_SLAVE;
                        rsp_rdata_d   = '0;
                        rsp_retries_d = '0;
                    end
                end
            end
            S_SEND: begin
                if (fall_tick) begin
                    if (cnt_q == req_len) begin
                        mosi_d  = 1'b0;
                        state_d = S_WAIT;
                        cnt_d   = '0;
                        tmr_d   = '0;
                    end else begin
                        mosi_d = tx_q[TXW-1];
                        tx_d   = {tx_q[TXW-2:0], 1'b0};
                        cnt_d  = cnt_q + 1'b1;
                    end
                end
            end
            S_WAIT: begin
                if (rise_tick) begin
                    if (saci_rsp_i) begin
                        state_d = S_RECV;
                        cnt_d   = BW'(1);
                        rx_d    = '0;
                    end else if (tmr_q == TO_LAST) begin
                        tmr_d = '0;
                        if (int'(retry_q) < g_retries) begin
                            state_d = S_RECOVER;
                            sel_n_d = '1;
                        end else begin
                            state_d       = S_DONE;
                            sel_n_d       = '1;
                            rsp_valid_d   = 1'b1;
                            rsp_status_d  = ST_TIMEOUT;
                            rsp_rdata_d   = '0;
                            rsp_retries_d = retry_q;
                        end
                    end else begin
                        tmr_d = tmr_q + 1'b1;
                    end
                end
            end
            S_RECOVER: begin
                if (tmr_q == REC_LAST) begin
                    state_d = S_SEND;
                    retry_d = retry_q + 1'b1;
                    tx_d    = q_frame;
                    cnt_d   = '0;
                    tmr_d   = '0;
                    for (int i = 0; i < g_num_slaves; i++) begin
                        sel_n_d[i] = (int'(slave_q) != i);
                    end
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end
            S_RECV: begin
                if (rise_tick) begin
                    rx_d  = rx_nxt[RXW-2:0];
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q + 1'b1 == rsp_len) begin
                        state_d       = S_DONE;
                        sel_n_d       = '1;
                        rsp_valid_d   = 1'b1;
                        rsp_retries_d = retry_q;
                        rsp_status_d  = (got_hdr == exp_hdr) ? ST_OK
                                                             : ST_ECHO_ERR;
                        rsp_rdata_d   = write_q ? '0 : rx_nxt[g_data_w-1:0];
                    end
                end
            end
            S_DONE: begin
                sel_n_d = '1;
                if (rsp_valid_q) begin
                    state_d = S_IDLE;
                end else begin
                    rsp_valid_d = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                sel_n_d = '1;
                mosi_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q       <= S_IDLE;
            write_q       <= 1'b0;
            slave_q       <= '0;
            cmd_q         <= '0;
            addr_q        <= '0;
            wdata_q       <= '0;
            tx_q          <= '0;
            rx_q          <= '0;
            cnt_q         <= '0;
            tmr_q         <= '0;
            retry_q       <= '0;
            sel_n_q       <= '1;
            mosi_q        <= 1'b0;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_status_q  <= ST_OK;
            rsp_retries_q <= '0;
        end else begin
            state_q       <= state_d;
            write_q       <= write_d;
            slave_q       <= slave_d;
            cmd_q         <= cmd_d;
            addr_q        <= addr_d;
            wdata_q       <= wdata_d;
            tx_q          <= tx_d;
            rx_q          <= rx_d;
            cnt_q         <= cnt_d;
            tmr_q         <= tmr_d;
            retry_q       <= retry_d;
            sel_n_q       <= sel_n_d;
            mosi_q        <= mosi_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_status_q  <= rsp_status_d;
            rsp_retries_q <= rsp_retries_d;
        end
    end

    assign req_ready_o   = (state_q == S_IDLE);
    assign busy_o        = (state_q != S_IDLE);
    assign rsp_valid_o   = rsp_valid_q;
    assign rsp_rdata_o   = rsp_rdata_q;
    assign rsp_status_o  = rsp_status_q;
    assign rsp_retries_o = rsp_retries_q;
    assign saci_cmd_o    = mosi_q;
    assign saci_sel_n_o  = sel_n_q;

endmodule

// File: tb/tb_saci_master_ctrl.sv
// tb_saci_master_ctrl: directed bench with a SACI slave model and a
// response scoreboard for saci_master_ctrl.
module tb_saci_master_ctrl;

    typedef struct {
        logic [1:0]  st;
        logic [31:0] rd;
        logic [1:0]  rt;
    } exp_rsp_t;

    typedef struct {
        logic [63:0] bits;
        int          len;
        logic [2:0]  sel;
    } exp_fr_t;

    logic        clk = 1'b0;
    logic        reset_i = 1'b1;
    logic        req_valid_i = 1'b0;
    logic        req_ready_o;
    logic        req_write_i = 1'b0;
    logic [1:0]  req_slave_i = '0;
    logic [6:0]  req_cmd_i = '0;
    logic [11:0] req_addr_i = '0;
    logic [31:0] req_wdata_i = '0;
    logic        rsp_valid_o;
    logic [31:0] rsp_rdata_o;
    logic [1:0]  rsp_status_o;
    logic [1:0]  rsp_retries_o;
    logic        busy_o;
    logic        saci_clk_o;
    logic        saci_cmd_o;
    logic [2:0]  saci_sel_n_o;
    logic        saci_rsp_i = 1'b0;

    int total = 0;
    int bad = 0;
    int n_rsp = 0;
    int n_gap = 0;
    int gap = 0;
    int mode = 0;
    logic [31:0] payload = 32'h0;

    exp_rsp_t exp_q[$];
    exp_fr_t  fr_q[$];
    exp_rsp_t mon_e;

    always #5 clk = ~clk;

    saci_master_ctrl dut (
        .clk_i         (clk),
        .reset_i       (reset_i),
        .req_valid_i   (req_valid_i),
        .req_ready_o   (req_ready_o),
        .req_write_i   (req_write_i),
        .req_slave_i   (req_slave_i),
        .req_cmd_i     (req_cmd_i),
        .req_addr_i    (req_addr_i),
        .req_wdata_i   (req_wdata_i),
        .rsp_valid_o   (rsp_valid_o),
        .rsp_rdata_o   (rsp_rdata_o),
        .rsp_status_o  (rsp_status_o),
        .rsp_retries_o (rsp_retries_o),
        .busy_o        (busy_o),
        .saci_clk_o    (saci_clk_o),
        .saci_cmd_o    (saci_cmd_o),
        .saci_sel_n_o  (saci_sel_n_o),
        .saci_rsp_i    (saci_rsp_i)
    );

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Scoreboard monitor: every completion pulse pops one expectation.
    always @(negedge clk) begin
        if (!reset_i && rsp_valid_o) begin
            n_rsp++;
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_rsp: status %0d expected none",
                         rsp_status_o);
            end else begin
                mon_e = exp_q.pop_front();
                chk("rsp_status", 64'(rsp_status_o), 64'(mon_e.st));
                chk("rsp_rdata", 64'(rsp_rdata_o), 64'(mon_e.rd));
                chk("rsp_retries", 64'(rsp_retries_o), 64'(mon_e.rt));
            end
        end
    end

    // Deselect gaps between retry attempts while the master is busy.
    always @(negedge clk) begin
        if (reset_i || !busy_o) begin
            gap = 0;
        end else if (&saci_sel_n_o) begin
            gap++;
        end else if (gap > 0) begin
            chk("recover_gap", 64'(gap), 64'(16));
            n_gap++;
            gap = 0;
        end
    end

    // Slave model: captures a frame on SACI rising edges, answers on falling.
    logic [63:0] sb, rb;
    logic [20:0] rh;
    logic [2:0]  csel;
    logic        rw, sbad;
    int          sn, need, rlen;
    exp_fr_t     ef;

    initial begin
        sn = 0;
        need = 21;
        forever begin
            @(posedge saci_clk_o);
            if (&saci_sel_n_o) begin
                sn = 0;
                continue;
            end
            if (sn == 0) begin
                if (saci_cmd_o !== 1'b1) continue;
                sb = 64'd1;
                sn = 1;
                need = 21;
                csel = saci_sel_n_o;
                sbad = 1'b0;
                continue;
            end
            sb = {sb[62:0], saci_cmd_o};
            sn++;
            if (saci_sel_n_o !== csel) sbad = 1'b1;
            if (sn == 2) begin
                rw = sb[0];
                need = rw ? 53 : 21;
            end
            if (sn == need) begin
                if (fr_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_frame: got %0h expected none", sb);
                end else begin
                    ef = fr_q.pop_front();
                    chk("frame_len", 64'(sn), 64'(ef.len));
                    chk("frame_bits", sb, ef.bits);
                    chk("frame_sel", 64'(csel), 64'(ef.sel));
                    chk("sel_stable", 64'(sbad), 64'(0));
                end
                sn = 0;
                if (mode != 2) begin
                    rh = sb[need-1 -: 21];
                    if (mode == 1) rh[11:0] = rh[11:0] + 12'd1;
                    if (rw) begin
                        rb = 64'(rh);
                        rlen = 21;
                    end else begin
                        rb = {11'b0, rh, payload};
                        rlen = 53;
                    end
                    for (int i = rlen - 1; i >= 0; i--) begin
                        @(negedge saci_clk_o);
                        saci_rsp_i = rb[i];
                    end
                    @(negedge saci_clk_o);
                    saci_rsp_i = 1'b0;
                end
            end
        end
    end

    task automatic push_fr(input logic [63:0] b, input int l,
                           input logic [2:0] s);
        exp_fr_t e;
        e.bits = b;
        e.len = l;
        e.sel = s;
        fr_q.push_back(e);
    endtask

    task automatic push_rsp(input logic [1:0] st, input logic [31:0] rd,
                            input logic [1:0] rt);
        exp_rsp_t e;
        e.st = st;
        e.rd = rd;
        e.rt = rt;
        exp_q.push_back(e);
    endtask

    task automatic issue(input logic wr, input logic [1:0] sl,
                         input logic [6:0] c, input logic [11:0] a,
                         input logic [31:0] d);
        int k;
        k = 0;
        @(negedge clk);
        while (!req_ready_o && k < 2000) begin
            @(negedge clk);
            k++;
        end
        if (!req_ready_o) begin
            total++;
            bad++;
            $display("FAIL ready_wait: got ready 0 expected 1");
        end
        req_write_i = wr;
        req_slave_i = sl;
        req_cmd_i   = c;
        req_addr_i  = a;
        req_wdata_i = d;
        req_valid_i = 1'b1;
        @(posedge clk);
        #1;
        req_valid_i = 1'b0;
    endtask

    task automatic wait_rsp(input int budget, input string nm);
        int start;
        int k;
        start = n_rsp;
        k = 0;
        while (n_rsp == start && k < budget) begin
            @(negedge clk);
            k++;
        end
        total++;
        if (n_rsp == start) begin
            bad++;
            $display("FAIL %s: no rsp_valid within %0d cycles, expected one",
                     nm, budget);
        end
    endtask

    int nb;
    int g0;

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", 64'(req_ready_o), 64'(1));
        chk("rst_busy", 64'(busy_o), 64'(0));
        chk("rst_valid", 64'(rsp_valid_o), 64'(0));
        chk("rst_rdata", 64'(rsp_rdata_o), 64'(0));
        chk("rst_status", 64'(rsp_status_o), 64'(0));
        chk("rst_retries", 64'(rsp_retries_o), 64'(0));
        chk("rst_sclk", 64'(saci_clk_o), 64'(0));
        chk("rst_cmd", 64'(saci_cmd_o), 64'(0));
        chk("rst_sel", 64'(saci_sel_n_o), 64'(3'b111));
        reset_i = 1'b0;

        // Write, correct echo.
        mode = 0;
        push_fr(64'({1'b1, 1'b1, 7'h05, 12'h123, 32'hDEADBEEF}), 53, 3'b101);
        push_rsp(2'd0, 32'h0, 2'd0);
        issue(1'b1, 2'd1, 7'h05, 12'h123, 32'hDEADBEEF);
        wait_rsp(1000, "write_done");

        // Read with payload.
        payload = 32'hCAFEF00D;
        push_fr(64'({1'b1, 1'b0, 7'h0A, 12'h7FF}), 21, 3'b110);
        push_rsp(2'd0, 32'hCAFEF00D, 2'd0);
        issue(1'b0, 2'd0, 7'h0A, 12'h7FF, 32'h55555555);
        wait_rsp(1000, "read_done");
        repeat (10) @(negedge clk);
        chk("rdata_hold", 64'(rsp_rdata_o), 64'(32'hCAFEF00D));

        // Stuck slave: four identical attempts, three recover gaps.
        mode = 2;
        g0 = n_gap;
        for (int i = 0; i < 4; i++) begin
            push_fr(64'({1'b1, 1'b0, 7'h11, 12'h055}), 21, 3'b011);
        end
        push_rsp(2'd1, 32'h0, 2'd3);
        issue(1'b0, 2'd2, 7'h11, 12'h055, 32'h0);
        wait_rsp(4000, "timeout_done");
        chk("recover_count", 64'(n_gap - g0), 64'(3));

        // Echo error: slave returns addr + 1.
        mode = 1;
        nb = n_rsp;
        push_fr(64'({1'b1, 1'b1, 7'h05, 12'h123, 32'h12345678}), 53, 3'b101);
        push_rsp(2'd2, 32'h0, 2'd0);
        issue(1'b1, 2'd1, 7'h05, 12'h123, 32'h12345678);
        wait_rsp(1000, "echo_done");
        repeat (20) @(negedge clk);
        chk("echo_pulses", 64'(n_rsp - nb), 64'(1));
        mode = 0;

        // Out-of-range slave.
        nb = n_rsp;
        push_rsp(2'd3, 32'h0, 2'd0);
        issue(1'b1, 2'd3, 7'h05, 12'h123, 32'h1);
        @(negedge clk);
        chk("bad_valid_c1", 64'(rsp_valid_o), 64'(0));
        chk("bad_busy_c1", 64'(busy_o), 64'(1));
        chk("bad_sel_c1", 64'(saci_sel_n_o), 64'(3'b111));
        @(negedge clk);
        chk("bad_valid_c2", 64'(rsp_valid_o), 64'(1));
        chk("bad_sel_c2", 64'(saci_sel_n_o), 64'(3'b111));
        chk("bad_cmd", 64'(saci_cmd_o), 64'(0));
        repeat (5) @(negedge clk);
        chk("bad_pulses", 64'(n_rsp - nb), 64'(1));

        // Reset mid-SEND, then a clean write.
        nb = n_rsp;
        issue(1'b1, 2'd0, 7'h01, 12'h010, 32'hFFFFFFFF);
        repeat (30) @(negedge clk);
        chk("pre_reset_busy", 64'(busy_o), 64'(1));
        reset_i = 1'b1;
        @(posedge clk);
        #1;
        chk("mid_rst_sel", 64'(saci_sel_n_o), 64'(3'b111));
        chk("mid_rst_ready", 64'(req_ready_o), 64'(1));
        chk("mid_rst_cmd", 64'(saci_cmd_o), 64'(0));
        chk("mid_rst_valid", 64'(rsp_valid_o), 64'(0));
        reset_i = 1'b0;
        repeat (400) @(negedge clk);
        chk("mid_rst_no_rsp", 64'(n_rsp - nb), 64'(0));
        push_fr(64'({1'b1, 1'b1, 7'h3C, 12'hABC, 32'h0F0F1234}), 53, 3'b110);
        push_rsp(2'd0, 32'h0, 2'd0);
        issue(1'b1, 2'd0, 7'h3C, 12'hABC, 32'h0F0F1234);
        wait_rsp(1000, "post_reset_done");

        repeat (10) @(negedge clk);
        chk("exp_q_left", 64'(exp_q.size()), 64'(0));
        chk("fr_q_left", 64'(fr_q.size()), 64'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation still running at time limit");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/saci_master_ctrl.md
# saci_master_ctrl

Synthesisable, parametrised SACI master for chip configuration. It replaces the simulation-only master and sits between a register-bus bridge (request/response handshake) and the SACI pins of one or more slave ASICs. It serialises read and write frames and generates the SACI clock from the system clock. It checks the slave's echoed header, recovers a stuck slave by deselect-and-retry, and reports status per transaction instead of asserting.

## Interface
Parameters:
- g_cmd_w, 7, command field width
- g_addr_w, 12, address field width
- g_data_w, 32, payload width
- g_num_slaves, 3, number of chip selects
- g_clk_half, 2, system clocks per SACI clock half-period (≥1); bit period P = 2·g_clk_half
- g_timeout, 100, bit periods waited for a response start bit
- g_retries, 3, retries after the first attempt
- g_recover, 4, bit periods that all selects stay deasserted before a retry

Ports:
- clk_i  in  1  system clock
- reset_i  in  1  synchronous, active-high reset
- req_valid_i  in  1  request valid
- req_ready_o  out  1  master ready; high only in IDLE
- req_write_i  in  1  1 = write, 0 = read
- req_slave_i  in  $clog2(g_num_slaves) (min 1)  target select index
- req_cmd_i  in  g_cmd_w  command
- req_addr_i  in  g_addr_w  address
- req_wdata_i  in  g_data_w  write payload
- rsp_valid_o  out  1  one-cycle completion pulse
- rsp_rdata_o  out  g_data_w  read payload; 0 for writes
- rsp_status_o  out  2  0 OK, 1 TIMEOUT, 2 ECHO_ERR, 3 BAD_SLAVE
- rsp_retries_o  out  $clog2(g_retries+1)  retries consumed
- busy_o  out  1  state ≠ IDLE
- saci_clk_o  out  1  SACI clock, free-running
- saci_cmd_o  out  1  MOSI
- saci_sel_n_o  out  g_num_slaves  active-low selects
- saci_rsp_i  in  1  MISO (same clock domain, not synchronised here)

## Operation
- Frame header H = start(1)·rw(1)·cmd·addr, sent MSB-first; L_H = 2+g_cmd_w+g_addr_w (21 by default).
- Request length: write = L_H+g_data_w (53 by default); read = L_H.
- Response length, start bit included: write = L_H; read = L_H+g_data_w.
- States:
  - IDLE: accept when req_valid_i && req_ready_o. All request fields are registered. An out-of-range slave goes to DONE with BAD_SLAVE and no select asserted.
  - SEND: the selected saci_sel_n_o bit is driven low on the acceptance edge. The next bit is driven at each fall tick. At the fall tick after the last bit, saci_cmd_o returns to 0 and the state goes to WAIT.
  - WAIT: saci_rsp_i is sampled on each rise tick. A sample of 1 is the start bit and moves to RECV. If g_timeout rise ticks pass without a start bit, go to RECOVER while retries < g_retries; otherwise go to DONE with TIMEOUT.
  - RECOVER: all selects are high for g_recover bit periods. Then the retry counter increments and the state returns to SEND from bit 0 with the same data.
  - RECV: the remaining response bits are shifted in on rise ticks. The returned rw, cmd and addr must equal the request, otherwise the status is ECHO_ERR. For reads, rsp_rdata_o is the last g_data_w bits received.
  - DONE: selects go high, rsp_valid_o pulses for one cycle, then the state returns to IDLE.
- saci_rsp_i is ignored outside WAIT and RECV.
- Requests presented while busy are ignored; req_ready_o is 0.

## Timing
- The SACI clock divider runs continuously after reset. saci_clk_o is low for g_clk_half cycles, then high for g_clk_half cycles.
- The fall tick is the cycle on which saci_clk_o goes 0. The rise tick is the cycle on which saci_clk_o goes 1.
- Acceptance to the first bit on saci_cmd_o: at most P cycles (waits for the next fall tick).
- Last response bit sampled → rsp_valid_o on the next cycle; the select is high on the same edge.
- BAD_SLAVE: rsp_valid_o is high 2 cycles after acceptance.
- Reset values: state IDLE, req_ready_o 1, busy_o 0, rsp_valid_o 0, rsp_rdata_o 0, rsp_status_o 0, rsp_retries_o 0, saci_clk_o 0, saci_cmd_o 0, saci_sel_n_o all 1. The divider count restarts at 0.
- Reset mid-transaction aborts on that edge: the above values hold next cycle and no rsp_valid_o is issued.
- The rsp_* outputs hold their values until the next acceptance.

## Structure
- Package saci_pkg: the state enum, the status enum (OK, TIMEOUT, ECHO_ERR, BAD_SLAVE), and functions for frame lengths given the widths.
- Sub-module saci_clk_gen: a divider producing saci_clk_o plus the fall_tick and rise_tick strobes, parametrised by g_clk_half.
- The FSM, shift registers and counters live in saci_master_ctrl.

## Test plan
- Write: slave 1, cmd 0x05, addr 0x123, data 0xDEADBEEF, g_clk_half 2. The slave model echoes a correct 21-bit response → 53 bits on saci_cmd_o; sel_n = 3'b101 for the whole frame; status OK, retries 0.
- Read: slave 0, addr 0x7FF. The slave model returns a 53-bit response with payload 0xCAFEF00D → rsp_rdata_o = 0xCAFEF00D, status OK.
- Stuck slave with no response start bit: 4 attempts, each separated by 4 bit periods of sel_n = 3'b111 → status TIMEOUT, retries 3.
- Slave returns addr 0x124 for request addr 0x123 → status ECHO_ERR, one rsp_valid_o pulse.
- req_slave_i = 3 with g_num_slaves 3 → no select asserted, saci_cmd_o stays 0, status BAD_SLAVE.
- reset_i asserted mid-SEND → next cycle all selects high and req_ready_o 1; no rsp_valid_o pulse; a following write completes OK.
